// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------
// Shares the byte-addressable memory port and the ASCII VGA text-buffer
// write port between two bus masters:
//   master 0 - processor core FSM
//   master 1 - program loader / debug port
// Requests are arbitrated round-robin. Addresses below VGA_BASE go to
// memory; addresses at or above VGA_BASE go to the ASCII text buffer.
// Each transaction ends with a one-cycle done pulse (plus err and, for
// reads, rdata) returned only to the master that was granted.
//
// Ports:
//   clk, rst                  clock (posedge) and async active-low reset
//   mN_req/addr/wdata/wsize   master N request; wsize 0 = read, else the
//                             write size code handed to memory
//   mN_rdata/done/err         master N response (valid while done is high)
//   mem_address/write/wdata   memory request outputs
//   mem_rdata/done/error      memory responses
//   vga_write_en/address/data ASCII buffer write strobe, address, data
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   When defined, a memory write that sees no mem_done for TIMEOUT_CYCLES
//   cycles is abandoned and reported with err = 1. When undefined, writes
//   wait for mem_done indefinitely and no watchdog counter exists.

module mem_bus_arbiter #(
    parameter int          WORD_SIZE      = 32,
    parameter logic [31:0] VGA_BASE       = 32'h0007_0000,
    parameter int          READ_WAIT      = 2,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_req,
    input  logic [31:0]          m0_addr,
    input  logic [WORD_SIZE-1:0] m0_wdata,
    input  logic [1:0]           m0_wsize,
    output logic [WORD_SIZE-1:0] m0_rdata,
    output logic                 m0_done,
    output logic                 m0_err,

    input  logic                 m1_req,
    input  logic [31:0]          m1_addr,
    input  logic [WORD_SIZE-1:0] m1_wdata,
    input  logic [1:0]           m1_wsize,
    output logic [WORD_SIZE-1:0] m1_rdata,
    output logic                 m1_done,
    output logic                 m1_err,

    output logic [31:0]          mem_address,
    output logic [1:0]           mem_write,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_done,
    input  logic                 mem_error,

    output logic                 vga_write_en,
    output logic [12:0]          vga_write_address,
    output logic [WORD_SIZE-1:0] vga_data
);

    // Elaboration-time parameter sanity checks.
    if (READ_WAIT < 1) begin : g_bad_read_wait
        $error("mem_bus_arbiter: READ_WAIT must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    // The read counter only ever holds READ_WAIT-1 down to 0.
    localparam int RW_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [RW_W-1:0] RW_LOAD = RW_W'(READ_WAIT - 1);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_READ_WAIT,
        S_WRITE_WAIT,
        S_VGA_WR,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 grant_q, grant_d;
    logic [31:0]          addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [1:0]           wsize_q, wsize_d;
    logic [RW_W-1:0]      rd_cnt_q, rd_cnt_d;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [TO_W-1:0]      wr_cnt_q, wr_cnt_d;
`endif

    logic [31:0]          mem_address_q, mem_address_d;
    logic [1:0]           mem_write_q, mem_write_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 vga_write_en_q, vga_write_en_d;
    logic [12:0]          vga_write_address_q, vga_write_address_d;
    logic [WORD_SIZE-1:0] vga_data_q, vga_data_d;
    logic [WORD_SIZE-1:0] m0_rdata_q, m0_rdata_d;
    logic [WORD_SIZE-1:0] m1_rdata_q, m1_rdata_d;
    logic                 m0_done_q, m0_done_d;
    logic                 m1_done_q, m1_done_d;
    logic                 m0_err_q, m0_err_d;
    logic                 m1_err_q, m1_err_d;

    logic                 pick;
    logic                 is_vga;
    logic                 is_write;
    logic                 resp_go;
    logic                 resp_err;
    logic                 resp_load;
    logic [WORD_SIZE-1:0] resp_rdata;

    // Next-state and registered-output computation. Every output is a flop
    // so the masters, memory and VGA buffer all see glitch-free signals.
    // Any state that finishes a transaction raises resp_go; the response
    // is then steered to the granted master at the bottom of the block.
    always_comb begin
        state_d             = state_q;
        last_grant_d        = last_grant_q;
        grant_d             = grant_q;
        addr_d              = addr_q;
        wdata_d             = wdata_q;
        wsize_d             = wsize_q;
        rd_cnt_d            = rd_cnt_q;
`ifdef MEM_ARB_TIMEOUT_EN
        wr_cnt_d            = wr_cnt_q;
`endif
        mem_address_d       = mem_address_q;
        mem_write_d         = mem_write_q;
        mem_wdata_d         = mem_wdata_q;
        vga_write_en_d      = 1'b0;
        vga_write_address_d = vga_write_address_q;
        vga_data_d          = vga_data_q;
        m0_rdata_d          = m0_rdata_q;
        m1_rdata_d          = m1_rdata_q;
        m0_done_d           = 1'b0;
        m1_done_d           = 1'b0;
        m0_err_d            = 1'b0;
        m1_err_d            = 1'b0;

        resp_go    = 1'b0;
        resp_err   = 1'b0;
        resp_load  = 1'b0;
        resp_rdata = '0;

        // Round-robin: on a tie the master that did not win last time goes.
        pick     = (m0_req && m1_req) ? ~last_grant_q : m1_req;
        is_vga   = (addr_q >= VGA_BASE);
        is_write = (wsize_q != 2'b00);

        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d       = pick;
                    last_grant_d  = pick;
                    addr_d        = pick ? m1_addr  : m0_addr;
                    wdata_d       = pick ? m1_wdata : m0_wdata;
                    wsize_d       = pick ? m1_wsize : m0_wsize;
                    mem_address_d = pick ? m1_addr  : m0_addr;
                    state_d       = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (!is_write && !is_vga) begin
                    rd_cnt_d = RW_LOAD;
                    state_d  = S_READ_WAIT;
                end else if (!is_write) begin
                    // The text buffer is write-only; reads of it fail.
                    resp_go   = 1'b1;
                    resp_err  = 1'b1;
                    resp_load = 1'b1;
                end else if (!is_vga) begin
                    mem_write_d = wsize_q;
                    mem_wdata_d = wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
                    wr_cnt_d    = '0;
`endif
                    state_d     = S_WRITE_WAIT;
                end else begin
                    vga_write_en_d      = 1'b1;
                    vga_write_address_d = addr_q[12:0];
                    vga_data_d          = wdata_q;
                    state_d             = S_VGA_WR;
                end
            end

            S_READ_WAIT: begin
                if (rd_cnt_q == '0) begin
                    resp_go    = 1'b1;
                    resp_err   = mem_error;
                    resp_load  = 1'b1;
                    resp_rdata = mem_rdata;
                end else begin
                    rd_cnt_d = rd_cnt_q - 1'b1;
                end
            end

            S_WRITE_WAIT: begin
                // An alignment error ends the write at once, even when the
                // memory never raises mem_done for it.
                if (mem_done || mem_error) begin
                    mem_write_d = 2'b00;
                    resp_go     = 1'b1;
                    resp_err    = mem_error;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wr_cnt_q == TO_LAST) begin
                    mem_write_d = 2'b00;
                    resp_go     = 1'b1;
                    resp_err    = 1'b1;
                end else begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
`endif
            end

            S_VGA_WR: begin
                resp_go = 1'b1;
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (resp_go) begin
            state_d = S_RESP;
            if (grant_q) begin
                m1_done_d = 1'b1;
                m1_err_d  = resp_err;
                if (resp_load) begin
                    m1_rdata_d = resp_rdata;
                end
            end else begin
                m0_done_d = 1'b1;
                m0_err_d  = resp_err;
                if (resp_load) begin
                    m0_rdata_d = resp_rdata;
                end
            end
        end
    end

    // State and output registers. last_grant resets to 1 so master 0 wins
    // the first tie; reset also drops mem_write and vga_write_en at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q             <= S_IDLE;
            last_grant_q        <= 1'b1;
            grant_q             <= 1'b0;
            addr_q              <= '0;
            wdata_q             <= '0;
            wsize_q             <= '0;
            rd_cnt_q            <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wr_cnt_q            <= '0;
`endif
            mem_address_q       <= '0;
            mem_write_q         <= '0;
            mem_wdata_q         <= '0;
            vga_write_en_q      <= 1'b0;
            vga_write_address_q <= '0;
            vga_data_q          <= '0;
            m0_rdata_q          <= '0;
            m1_rdata_q          <= '0;
            m0_done_q           <= 1'b0;
            m1_done_q           <= 1'b0;
            m0_err_q            <= 1'b0;
            m1_err_q            <= 1'b0;
        end else begin
            state_q             <= state_d;
            last_grant_q        <= last_grant_d;
            grant_q             <= grant_d;
            addr_q              <= addr_d;
            wdata_q             <= wdata_d;
            wsize_q             <= wsize_d;
            rd_cnt_q            <= rd_cnt_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wr_cnt_q            <= wr_cnt_d;
`endif
            mem_address_q       <= mem_address_d;
            mem_write_q         <= mem_write_d;
            mem_wdata_q         <= mem_wdata_d;
            vga_write_en_q      <= vga_write_en_d;
            vga_write_address_q <= vga_write_address_d;
            vga_data_q          <= vga_data_d;
            m0_rdata_q          <= m0_rdata_d;
            m1_rdata_q          <= m1_rdata_d;
            m0_done_q           <= m0_done_d;
            m1_done_q           <= m1_done_d;
            m0_err_q            <= m0_err_d;
            m1_err_q            <= m1_err_d;
        end
    end

    assign m0_rdata          = m0_rdata_q;
    assign m0_done           = m0_done_q;
    assign m0_err            = m0_err_q;
    assign m1_rdata          = m1_rdata_q;
    assign m1_done           = m1_done_q;
    assign m1_err            = m1_err_q;
    assign mem_address       = mem_address_q;
    assign mem_write         = mem_write_q;
    assign mem_wdata         = mem_wdata_q;
    assign vga_write_en      = vga_write_en_q;
    assign vga_write_address = vga_write_address_q;
    assign vga_data          = vga_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// ------------------
// Directed bench for mem_bus_arbiter: single reads and writes on each
// port, VGA routing at the base address, error paths, round-robin
// alternation under contention, and reset in the middle of a write.
// Optional macro MEM_ARB_TIMEOUT_EN adds the write-watchdog scenario.

module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [1:0]  m0_wsize, m1_wsize;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m1_done, m0_err, m1_err;
    logic [31:0] mem_address;
    logic [1:0]  mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done, mem_error;
    logic        vga_write_en;
    logic [12:0] vga_write_address;
    logic [31:0] vga_data;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .WORD_SIZE      (32),
        .VGA_BASE       (32'h0007_0000),
        .READ_WAIT      (2),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .m0_req            (m0_req),
        .m0_addr           (m0_addr),
        .m0_wdata          (m0_wdata),
        .m0_wsize          (m0_wsize),
        .m0_rdata          (m0_rdata),
        .m0_done           (m0_done),
        .m0_err            (m0_err),
        .m1_req            (m1_req),
        .m1_addr           (m1_addr),
        .m1_wdata          (m1_wdata),
        .m1_wsize          (m1_wsize),
        .m1_rdata          (m1_rdata),
        .m1_done           (m1_done),
        .m1_err            (m1_err),
        .mem_address       (mem_address),
        .mem_write         (mem_write),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_done          (mem_done),
        .mem_error         (mem_error),
        .vga_write_en      (vga_write_en),
        .vga_write_address (vga_write_address),
        .vga_data          (vga_data)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge, where outputs are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise a request on one master with the given address, data and size.
    task automatic applyStimulus(input int master, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] wsize);
        if (master == 0) begin
            m0_req   = 1'b1;
            m0_addr  = addr;
            m0_wdata = wdata;
            m0_wsize = wsize;
        end else begin
            m1_req   = 1'b1;
            m1_addr  = addr;
            m1_wdata = wdata;
            m1_wsize = wsize;
        end
    endtask

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Directed scenario sequence.
    initial begin
        int n;

        rst       = 1'b0;
        m0_req    = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wsize = '0;
        m1_req    = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wsize = '0;
        mem_rdata = '0;
        mem_done  = 1'b0;
        mem_error = 1'b0;

        step();
        step();
        checkOutput("reset_m0_done",     m0_done,      32'd0);
        checkOutput("reset_m1_done",     m1_done,      32'd0);
        checkOutput("reset_mem_write",   mem_write,    32'd0);
        checkOutput("reset_vga_en",      vga_write_en, 32'd0);
        checkOutput("reset_mem_address", mem_address,  32'd0);
        checkOutput("reset_m0_rdata",    m0_rdata,     32'd0);
        rst = 1'b1;
        step();

        $display("[TB] m0 memory read");
        mem_rdata = 32'hDEAD_BEEF;
        applyStimulus(0, 32'h0000_0010, 32'h0, 2'b00);
        step();
        checkOutput("rd_issue_addr", mem_address, 32'h0000_0010);
        step();
        step();
        checkOutput("rd_early_done", m0_done, 32'd0);
        step();
        checkOutput("rd_done",    m0_done,  32'd1);
        checkOutput("rd_rdata",   m0_rdata, 32'hDEAD_BEEF);
        checkOutput("rd_err",     m0_err,   32'd0);
        checkOutput("rd_m1_done", m1_done,  32'd0);
        m0_req = 1'b0;
        step();
        checkOutput("rd_done_one_cycle", m0_done,  32'd0);
        checkOutput("rd_rdata_hold",     m0_rdata, 32'hDEAD_BEEF);

        $display("[TB] m1 VGA write");
        applyStimulus(1, 32'h0007_0005, 32'h0000_0041, 2'b10);
        step();
        checkOutput("vga_issue_en", vga_write_en, 32'd0);
        step();
        checkOutput("vga_en",        vga_write_en,      32'd1);
        checkOutput("vga_addr",      vga_write_address, 32'h0005);
        checkOutput("vga_data",      vga_data,          32'h41);
        checkOutput("vga_mem_write", mem_write,         32'd0);
        step();
        checkOutput("vga_en_one_cycle", vga_write_en, 32'd0);
        checkOutput("vga_m1_done",      m1_done,      32'd1);
        checkOutput("vga_m1_err",       m1_err,       32'd0);
        checkOutput("vga_m0_done",      m0_done,      32'd0);
        checkOutput("vga_mem_write2",   mem_write,    32'd0);
        m1_req = 1'b0;
        step();
        checkOutput("vga_done_one_cycle", m1_done, 32'd0);

        $display("[TB] m0 memory write with slow mem_done");
        applyStimulus(0, 32'h0000_0100, 32'hCAFE_F00D, 2'b11);
        step();
        checkOutput("wr_issue_mem_write", mem_write, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput($sformatf("wr_hold_%0d", i), mem_write, 32'd3);
            checkOutput($sformatf("wr_wait_done_%0d", i), m0_done, 32'd0);
            if (i == 0) begin
                checkOutput("wr_wdata", mem_wdata, 32'hCAFE_F00D);
            end
        end
        mem_done = 1'b1;
        step();
        checkOutput("wr_mem_write_off", mem_write, 32'd0);
        checkOutput("wr_done",          m0_done,   32'd1);
        checkOutput("wr_err",           m0_err,    32'd0);
        mem_done = 1'b0;
        m0_req   = 1'b0;
        step();

        $display("[TB] m0 read of VGA base");
        applyStimulus(0, 32'h0007_0000, 32'h0, 2'b00);
        step();
        step();
        checkOutput("vgard_done",  m0_done,  32'd1);
        checkOutput("vgard_err",   m0_err,   32'd1);
        checkOutput("vgard_rdata", m0_rdata, 32'd0);
        m0_req = 1'b0;
        step();
        checkOutput("vgard_err_clear", m0_err, 32'd0);

        $display("[TB] m0 read just below VGA base with mem_error");
        mem_rdata = 32'h1234_5678;
        mem_error = 1'b1;
        applyStimulus(0, 32'h0006_FFFC, 32'h0, 2'b00);
        step();
        step();
        step();
        checkOutput("rderr_early_done", m0_done, 32'd0);
        step();
        checkOutput("rderr_done",  m0_done,  32'd1);
        checkOutput("rderr_err",   m0_err,   32'd1);
        checkOutput("rderr_rdata", m0_rdata, 32'h1234_5678);
        mem_error = 1'b0;
        m0_req    = 1'b0;
        step();

        $display("[TB] contention after reset");
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        mem_rdata = 32'hA5A5_0001;
        applyStimulus(0, 32'h0000_0040, 32'h0, 2'b00);
        applyStimulus(1, 32'h0000_0080, 32'h0, 2'b00);
        for (int t = 0; t < 4; t++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!m0_done && !m1_done && n < 12);
            checkOutput($sformatf("alt_m0_done_%0d", t), m0_done, (t % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("alt_m1_done_%0d", t), m1_done, (t % 2 == 1) ? 32'd1 : 32'd0);
            checkOutput($sformatf("alt_latency_%0d", t), n, (t == 0) ? 32'd4 : 32'd5);
            if (t % 2 == 1) begin
                checkOutput($sformatf("alt_m1_rdata_%0d", t), m1_rdata, 32'hA5A5_0001);
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();

        $display("[TB] reset during write wait");
        applyStimulus(0, 32'h0000_0200, 32'h0000_0055, 2'b01);
        step();
        step();
        checkOutput("rstwr_mem_write_on", mem_write, 32'd1);
        rst    = 1'b0;
        m0_req = 1'b0;
        #1;
        checkOutput("rstwr_mem_write_off", mem_write, 32'd0);
        checkOutput("rstwr_done_low",      m0_done,   32'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("rstwr_no_done_%0d", i), m0_done, 32'd0);
            checkOutput($sformatf("rstwr_idle_write_%0d", i), mem_write, 32'd0);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        $display("[TB] write watchdog");
        mem_done = 1'b0;
        applyStimulus(0, 32'h0000_0300, 32'h0000_0077, 2'b11);
        n = 0;
        do begin
            step();
            n++;
        end while (!m0_done && n < 100);
        checkOutput("to_latency",   n,         32'd66);
        checkOutput("to_done",      m0_done,   32'd1);
        checkOutput("to_err",       m0_err,    32'd1);
        checkOutput("to_mem_write", mem_write, 32'd0);
        m0_req = 1'b0;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
